// File: rtl/regfile_sb_pkg.sv
// Shared defaults and width helpers for the scoreboarded register file.
package regfile_sb_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;
    localparam int DEF_NRD  = 2;
    localparam int DEF_NWR  = 2;

    // Address width for a register count; a single-register file still needs one bit.
    function automatic int addrWidth(input int nreg);
        return (nreg < 2) ? 1 : $clog2(nreg);
    endfunction

    // Width needed to hold a population count of 0..nreg.
    function automatic int cntWidth(input int nreg);
        return $clog2(nreg + 1);
    endfunction

endpackage

// File: rtl/regfile_sb_wsel.sv
// Per-register write resolution: the highest-index enabled port wins, and
// any second hit on the same nonzero register flags a conflict.
module regfile_sb_wsel
    import regfile_sb_pkg::*;
#(
    parameter  int XLEN = DEF_XLEN,
    parameter  int NREG = DEF_NREG,
    parameter  int NWR  = DEF_NWR,
    localparam int AW   = addrWidth(NREG)
) (
    input  logic [NWR*AW-1:0]            waddr_i,
    input  logic [NWR*XLEN-1:0]          wdata_i,
    input  logic [NWR-1:0]               wena_i,
    output logic [NREG-1:0]              hit_o,
    output logic [NREG-1:0][XLEN-1:0]    data_o,
    output logic                         conflict_o
);

    // Register 0 is skipped so it never hits, never forwards and never conflicts.
    always_comb begin
        hit_o      = '0;
        data_o     = '0;
        conflict_o = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            for (int j = 0; j < NWR; j++) begin
                if (wena_i[j] && (waddr_i[j*AW +: AW] == AW'(r))) begin
                    if (hit_o[r]) begin
                        conflict_o = 1'b1;
                    end
                    hit_o[r]  = 1'b1;
                    data_o[r] = wdata_i[j*XLEN +: XLEN];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-ported register file with optional write-to-read forwarding and a
// busy-bit scoreboard that tracks destinations reserved by issued instructions.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter  int XLEN   = DEF_XLEN,
    parameter  int NREG   = DEF_NREG,
    parameter  int NRD    = DEF_NRD,
    parameter  int NWR    = DEF_NWR,
    parameter  int BYPASS = 1,
    localparam int AW     = addrWidth(NREG),
    localparam int CW     = cntWidth(NREG)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NRD*AW-1:0]     i_raddr,
    output logic [NRD*XLEN-1:0]   o_rdata,
    output logic [NRD-1:0]        o_rbusy,
    input  logic [NWR*AW-1:0]     i_waddr,
    input  logic [NWR*XLEN-1:0]   i_wdata,
    input  logic [NWR-1:0]        i_wena,
    input  logic                  i_iss_vld,
    input  logic [AW-1:0]         i_iss_rd,
    output logic                  o_iss_rdy,
    output logic [CW-1:0]         o_busy_cnt,
    output logic                  o_wr_conflict
);

    logic [NREG-1:0][XLEN-1:0] regs_q, regs_d;
    logic [NREG-1:0]           busy_q, busy_d;
    logic [CW-1:0]             busyCnt_q, busyCnt_d;
    logic                      wrConflict_q;

    logic [NREG-1:0]           wrHit;
    logic [NREG-1:0][XLEN-1:0] wrData;
    logic                      wrConflict;
    logic                      issAccept;
    logic [AW-1:0]             rAddr;
    logic                      rFwd;

    regfile_sb_wsel #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NWR  (NWR)
    ) u_wsel (
        .waddr_i    (i_waddr),
        .wdata_i    (i_wdata),
        .wena_i     (i_wena),
        .hit_o      (wrHit),
        .data_o     (wrData),
        .conflict_o (wrConflict)
    );

    // A write landing this cycle frees the register, so an issue to it can proceed.
    assign o_iss_rdy = ~busy_q[i_iss_rd] | wrHit[i_iss_rd] | (i_iss_rd == '0);
    assign issAccept = i_iss_vld & o_iss_rdy & (i_iss_rd != '0);

    // The issue reservation is applied after write clears, so issue wins on a tie.
    always_comb begin
        regs_d    = regs_q;
        busy_d    = busy_q & ~wrHit;
        busyCnt_d = '0;
        for (int r = 0; r < NREG; r++) begin
            if (wrHit[r]) begin
                regs_d[r] = wrData[r];
            end
        end
        if (issAccept) begin
            busy_d[i_iss_rd] = 1'b1;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            busyCnt_d = busyCnt_d + CW'(busy_d[r]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            regs_q       <= '0;
            busy_q       <= '0;
            busyCnt_q    <= '0;
            wrConflict_q <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            busy_q       <= busy_d;
            busyCnt_q    <= busyCnt_d;
            wrConflict_q <= wrConflict;
        end
    end

    // Forwarded reads also hide the busy flag, since the value is already here.
    always_comb begin
        o_rdata = '0;
        o_rbusy = '0;
        rAddr   = '0;
        rFwd    = 1'b0;
        for (int k = 0; k < NRD; k++) begin
            rAddr = i_raddr[k*AW +: AW];
            rFwd  = (BYPASS != 0) && wrHit[rAddr];
            if (rAddr != '0) begin
                o_rdata[k*XLEN +: XLEN] = rFwd ? wrData[rAddr] : regs_q[rAddr];
                o_rbusy[k]              = busy_q[rAddr] & ~rFwd;
            end
        end
    end

    assign o_busy_cnt    = busyCnt_q;
    assign o_wr_conflict = wrConflict_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, hand-written reset/bypass
// sequences and randomized traffic against an array-based reference model.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;
    localparam int CW   = 6;

    logic                 i_clk = 1'b0;
    logic                 i_rst_n;
    logic [NRD*AW-1:0]    i_raddr;
    logic [NWR*AW-1:0]    i_waddr;
    logic [NWR*XLEN-1:0]  i_wdata;
    logic [NWR-1:0]       i_wena;
    logic                 i_iss_vld;
    logic [AW-1:0]        i_iss_rd;

    logic [NRD*XLEN-1:0]  rdataByp, rdataNoByp;
    logic [NRD-1:0]       rbusyByp, rbusyNoByp;
    logic                 issRdyByp, issRdyNoByp;
    logic [CW-1:0]        busyCntByp, busyCntNoByp;
    logic                 conflictByp, conflictNoByp;

    int nTests = 0;
    int nFail  = 0;

    logic [XLEN-1:0] mReg [NREG];
    bit              mBusy [NREG];
    int              mCnt;
    bit              mConf;

    typedef struct {
        logic            rst;
        logic [AW-1:0]   ra0, ra1;
        logic            we0;
        logic [AW-1:0]   wa0;
        logic [XLEN-1:0] wd0;
        logic            we1;
        logic [AW-1:0]   wa1;
        logic [XLEN-1:0] wd1;
        logic            iv;
        logic [AW-1:0]   ir;
        logic [XLEN-1:0] er0, er1;
        logic [1:0]      erb;
        logic            erdy;
        logic [CW-1:0]   ecnt;
        logic            econf;
    } vec_t;

    vec_t vecs [12];

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dutByp (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_raddr(i_raddr), .o_rdata(rdataByp),
        .o_rbusy(rbusyByp), .i_waddr(i_waddr), .i_wdata(i_wdata), .i_wena(i_wena),
        .i_iss_vld(i_iss_vld), .i_iss_rd(i_iss_rd), .o_iss_rdy(issRdyByp),
        .o_busy_cnt(busyCntByp), .o_wr_conflict(conflictByp)
    );

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dutNoByp (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_raddr(i_raddr), .o_rdata(rdataNoByp),
        .o_rbusy(rbusyNoByp), .i_waddr(i_waddr), .i_wdata(i_wdata), .i_wena(i_wena),
        .i_iss_vld(i_iss_vld), .i_iss_rd(i_iss_rd), .o_iss_rdy(issRdyNoByp),
        .o_busy_cnt(busyCntNoByp), .o_wr_conflict(conflictNoByp)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit anyWrite(input int a);
        for (int j = 0; j < NWR; j++) begin
            if (i_wena[j] && int'(i_waddr[j*AW +: AW]) == a && a != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [XLEN-1:0] expRdata(input int k, input bit byp);
        int a = int'(i_raddr[k*AW +: AW]);
        logic [XLEN-1:0] v;
        if (a == 0) return '0;
        v = mReg[a];
        if (byp) begin
            for (int j = 0; j < NWR; j++) begin
                if (i_wena[j] && int'(i_waddr[j*AW +: AW]) == a) v = i_wdata[j*XLEN +: XLEN];
            end
        end
        return v;
    endfunction

    function automatic bit expRbusy(input int k, input bit byp);
        int a = int'(i_raddr[k*AW +: AW]);
        if (a == 0) return 1'b0;
        if (byp && anyWrite(a)) return 1'b0;
        return mBusy[a];
    endfunction

    function automatic bit expIssRdy();
        int rd = int'(i_iss_rd);
        return (rd == 0) || !mBusy[rd] || anyWrite(rd);
    endfunction

    // Reference model of one rising edge, applied from the current inputs.
    task automatic modelEdge();
        int hits [NREG];
        bit rdy;
        if (!i_rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                mReg[r]  = '0;
                mBusy[r] = 1'b0;
            end
            mConf = 1'b0;
        end else begin
            rdy   = expIssRdy();
            mConf = 1'b0;
            for (int r = 0; r < NREG; r++) hits[r] = 0;
            for (int j = 0; j < NWR; j++) begin
                int a = int'(i_waddr[j*AW +: AW]);
                if (i_wena[j] && a != 0) begin
                    mReg[a]  = i_wdata[j*XLEN +: XLEN];
                    mBusy[a] = 1'b0;
                    hits[a]++;
                    if (hits[a] == 2) mConf = 1'b1;
                end
            end
            if (i_iss_vld && rdy && i_iss_rd != '0) mBusy[int'(i_iss_rd)] = 1'b1;
        end
        mCnt = 0;
        for (int r = 0; r < NREG; r++) mCnt += int'(mBusy[r]);
    endtask

    task automatic setIdle();
        i_raddr   = '0;
        i_waddr   = '0;
        i_wdata   = '0;
        i_wena    = '0;
        i_iss_vld = 1'b0;
        i_iss_rd  = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        i_rst_n   = v.rst;
        i_raddr   = {v.ra1, v.ra0};
        i_waddr   = {v.wa1, v.wa0};
        i_wdata   = {v.wd1, v.wd0};
        i_wena    = {v.we1, v.we0};
        i_iss_vld = v.iv;
        i_iss_rd  = v.ir;
    endtask

    // Compare both DUTs against the model before and after one edge.
    task automatic stepChecked();
        #1;
        for (int k = 0; k < NRD; k++) begin
            checkOutput($sformatf("rdata%0d byp", k), 64'(rdataByp[k*XLEN +: XLEN]), 64'(expRdata(k, 1'b1)));
            checkOutput($sformatf("rdata%0d nobyp", k), 64'(rdataNoByp[k*XLEN +: XLEN]), 64'(expRdata(k, 1'b0)));
            checkOutput($sformatf("rbusy%0d byp", k), 64'(rbusyByp[k]), 64'(expRbusy(k, 1'b1)));
            checkOutput($sformatf("rbusy%0d nobyp", k), 64'(rbusyNoByp[k]), 64'(expRbusy(k, 1'b0)));
        end
        checkOutput("iss_rdy byp", 64'(issRdyByp), 64'(expIssRdy()));
        checkOutput("iss_rdy nobyp", 64'(issRdyNoByp), 64'(expIssRdy()));
        @(posedge i_clk);
        modelEdge();
        #1;
        checkOutput("busy_cnt byp", 64'(busyCntByp), 64'(mCnt));
        checkOutput("busy_cnt nobyp", 64'(busyCntNoByp), 64'(mCnt));
        checkOutput("wr_conflict byp", 64'(conflictByp), 64'(mConf));
        checkOutput("wr_conflict nobyp", 64'(conflictNoByp), 64'(mConf));
    endtask

    function automatic logic [AW-1:0] randAddr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, NREG - 1));
    endfunction

    initial begin
        //             rst   ra0    ra1    we0   wa0    wd0            we1   wa1    wd1            iv    ir     er0            er1            erb    erdy  ecnt   econf
        vecs[0]  = '{1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'h12345678, 32'h12345678, 2'b00, 1'b1, 6'd0, 1'b1};
        vecs[1]  = '{1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h12345678, 32'h12345678, 2'b00, 1'b1, 6'd0, 1'b0};
        vecs[2]  = '{1'b1, 5'd7, 5'd5, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'hA5A5A5A5, 32'h12345678, 2'b00, 1'b1, 6'd0, 1'b0};
        vecs[3]  = '{1'b1, 5'd3, 5'd7, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h0,        32'hA5A5A5A5, 2'b00, 1'b1, 6'd1, 1'b0};
        vecs[4]  = '{1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h0,        32'h0,        2'b01, 1'b0, 6'd1, 1'b0};
        vecs[5]  = '{1'b1, 5'd3, 5'd3, 1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h11,       1'b0, 5'd0, 32'h11,       32'h11,       2'b00, 1'b1, 6'd0, 1'b0};
        vecs[6]  = '{1'b1, 5'd3, 5'd3, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h11,       32'h11,       2'b00, 1'b1, 6'd0, 1'b0};
        vecs[7]  = '{1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h0,        32'h0,        2'b00, 1'b1, 6'd1, 1'b0};
        vecs[8]  = '{1'b1, 5'd9, 5'd9, 1'b1, 5'd9, 32'h22,       1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h22,       32'h22,       2'b00, 1'b1, 6'd1, 1'b0};
        vecs[9]  = '{1'b1, 5'd9, 5'd9, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd9, 32'h22,       32'h22,       2'b11, 1'b0, 6'd1, 1'b0};
        vecs[10] = '{1'b1, 5'd0, 5'd9, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd9, 32'h33,       1'b1, 5'd0, 32'h0,        32'h33,       2'b00, 1'b1, 6'd0, 1'b0};
        vecs[11] = '{1'b1, 5'd0, 5'd9, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        32'h33,       2'b00, 1'b1, 6'd0, 1'b0};

        // Reset from power-up; outputs are undefined until the first edge.
        setIdle();
        i_rst_n = 1'b0;
        repeat (2) begin
            @(posedge i_clk);
            modelEdge();
        end
        #1;
        checkOutput("reset busy_cnt", 64'(busyCntByp), 64'd0);
        checkOutput("reset wr_conflict", 64'(conflictByp), 64'd0);
        i_rst_n = 1'b1;

        // Read sweep over every address after reset.
        for (int a = 0; a < NREG; a++) begin
            i_raddr = {AW'(NREG - 1 - a), AW'(a)};
            #1;
            checkOutput($sformatf("sweep x%0d rdata", a), 64'(rdataByp), 64'd0);
            checkOutput($sformatf("sweep x%0d rbusy", a), 64'(rbusyByp), 64'd0);
            stepChecked();
        end

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d rdata0", i), 64'(rdataByp[XLEN-1:0]), 64'(vecs[i].er0));
            checkOutput($sformatf("vec%0d rdata1", i), 64'(rdataByp[2*XLEN-1:XLEN]), 64'(vecs[i].er1));
            checkOutput($sformatf("vec%0d rbusy", i), 64'(rbusyByp), 64'(vecs[i].erb));
            checkOutput($sformatf("vec%0d iss_rdy", i), 64'(issRdyByp), 64'(vecs[i].erdy));
            stepChecked();
            checkOutput($sformatf("vec%0d busy_cnt", i), 64'(busyCntByp), 64'(vecs[i].ecnt));
            checkOutput($sformatf("vec%0d wr_conflict", i), 64'(conflictByp), 64'(vecs[i].econf));
        end

        // Reserve four registers, then reset while they are outstanding.
        setIdle();
        for (int i = 0; i < 4; i++) begin
            i_iss_vld = 1'b1;
            i_iss_rd  = AW'(i == 0 ? 1 : 2 * i);
            stepChecked();
        end
        checkOutput("four busy cnt", 64'(busyCntByp), 64'd4);
        i_rst_n   = 1'b0;
        i_iss_rd  = 5'd8;
        i_wena    = 2'b01;
        i_waddr   = {5'd0, 5'd1};
        i_wdata   = {32'h0, 32'h55};
        stepChecked();
        checkOutput("post-reset busy_cnt", 64'(busyCntByp), 64'd0);
        i_rst_n   = 1'b1;
        setIdle();
        i_raddr   = {5'd2, 5'd1};
        #1;
        checkOutput("post-reset x1 x2 rdata", 64'(rdataByp), 64'd0);
        checkOutput("post-reset x1 x2 rbusy", 64'(rbusyByp), 64'd0);
        stepChecked();

        // Same-cycle write and read of x7 with and without forwarding.
        i_wena  = 2'b01;
        i_waddr = {5'd0, 5'd7};
        i_wdata = {32'h0, 32'hA5A5A5A5};
        i_raddr = {5'd0, 5'd7};
        #1;
        checkOutput("x7 bypass rdata", 64'(rdataByp[XLEN-1:0]), 64'hA5A5A5A5);
        checkOutput("x7 no-bypass rdata", 64'(rdataNoByp[XLEN-1:0]), 64'd0);
        stepChecked();

        // Randomized traffic, biased toward low registers to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            i_rst_n   = ($urandom_range(0, 63) != 0);
            i_raddr   = {randAddr(), randAddr()};
            i_waddr   = {randAddr(), randAddr()};
            i_wdata   = {$urandom, $urandom};
            i_wena    = NWR'($urandom_range(0, 3));
            i_iss_vld = ($urandom_range(0, 1) == 1);
            i_iss_rd  = randAddr();
            stepChecked();
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, register width in bits.
REQ-002 Parameter NREG, default 32, number of architectural registers (power of two, >=2); AW = clog2(NREG).
REQ-003 Parameter NRD, default 2, number of read ports.
REQ-004 Parameter NWR, default 2, number of write ports.
REQ-005 Parameter BYPASS, default 1, enables same-cycle write-to-read forwarding.
REQ-006 i_clk  in  1  clock; all state updates on rising edge.
REQ-007 i_rst_n  in  1  reset, synchronous, active-low.
REQ-008 i_raddr  in  NRD*AW  packed read addresses, port k at bits [k*AW +: AW].
REQ-009 o_rdata  out  NRD*XLEN  packed read data, combinational.
REQ-010 o_rbusy  out  NRD  per-read-port flag: addressed register has an outstanding writer.
REQ-011 i_waddr  in  NWR*AW  packed write addresses.
REQ-012 i_wdata  in  NWR*XLEN  packed write data.
REQ-013 i_wena  in  NWR  per-port write enable; a write also clears that register's busy bit.
REQ-014 i_iss_vld  in  1  issue request: reserve destination i_iss_rd.
REQ-015 i_iss_rd  in  AW  issue destination register.
REQ-016 o_iss_rdy  out  1  issue accepted this cycle, combinational.
REQ-017 o_busy_cnt  out  clog2(NREG+1)  registered count of busy registers.
REQ-018 o_wr_conflict  out  1  registered one-cycle pulse: two enabled write ports hit the same nonzero address in the previous cycle.

Function
REQ-019 Register 0 reads as zero, ignores writes and is never busy; issue to rd=0 is accepted and has no effect.
REQ-020 Writes commit at the rising edge when i_wena[j]=1 and i_waddr[j]!=0.
REQ-021 Same-address writes in one cycle: the highest-index port wins; o_wr_conflict=1 in the following cycle only.
REQ-022 BYPASS=1: read port returns the wdata of the highest-index enabled write port matching its nonzero address in the same cycle, else stored value; BYPASS=0: stored value only.
REQ-023 Scoreboard: one busy bit per register; accepted issue (i_iss_vld & o_iss_rdy & rd!=0) sets busy[rd] at the edge; an enabled write to r clears busy[r] at the edge.
REQ-024 o_iss_rdy = ~busy[i_iss_rd] | (some write enabled to i_iss_rd this cycle) | (i_iss_rd==0), independent of i_iss_vld.
REQ-025 Simultaneous write and accepted issue to the same register: data is written and busy[r] ends set (issue wins).
REQ-026 o_rbusy[k] = busy[raddr_k], masked to 0 when BYPASS=1 and a same-cycle write matches; always 0 for address 0.
REQ-027 o_busy_cnt equals the population count of busy bits after each edge; never exceeds NREG-1.
REQ-028 Only writes to the write ports change stored data; issues never modify data.

Reset
REQ-029 While i_rst_n=0 at an edge: all registers cleared to 0, all busy bits cleared, o_busy_cnt=0, o_wr_conflict=0.
REQ-030 Writes and issues presented in a reset cycle are discarded; reset mid-operation abandons all outstanding reservations.
REQ-031 Combinational outputs during reset follow the (cleared) state and the current inputs.

Structure
REQ-032 Shared package holds the default XLEN/NREG/NRD/NWR constants and the AW/count-width helper functions.
REQ-033 One sub-module, regfile_sb_wsel, resolves the winning write port per address (used by write, bypass and conflict detection).

Verification
REQ-034 Reset then read all ports at addresses 0..31 -> all 0, o_busy_cnt=0, o_rbusy=0.
REQ-035 Write port0 x5=0xDEADBEEF and port1 x5=0x12345678 in the same cycle -> next-cycle read of x5 returns 0x12345678, o_wr_conflict=1 for one cycle.
REQ-036 BYPASS=1: write x7=0xA5A5A5A5 while reading x7 in the same cycle -> o_rdata=0xA5A5A5A5 combinationally; BYPASS=0 -> old value 0.
REQ-037 Issue rd=3 -> o_busy_cnt=1, o_rbusy=1 on x3, second issue to rd=3 gives o_iss_rdy=0; write x3=0x11 -> busy cleared, count 0.
REQ-038 With x9 busy, issue rd=9 and write x9=0x22 in the same cycle -> o_iss_rdy=1, x9 reads 0x22, busy[9]=1, count unchanged.
REQ-039 Issue rd=0 and write x0=0xFFFFFFFF -> x0 reads 0, count 0; assert reset while 4 registers busy -> count 0 and all busy cleared next cycle.
